alu_operand_stage: RTL
======================

// Module: alu_operand_stage
//
// PURPOSE
//   Operand staging register directly upstream of the ALU.
//   - Accepts one microinstruction issue per handshake: ALU op plus A/B source selects.
//   - Selects each operand from register file, immediate, memory data or zero.
//   - Stalls for memory read data when a source needs it.
//   - Presents registered a/b/op to the ALU with a valid/ready handshake.
//
// PARAMETERS
//   WIDTH    16                  operand width in bits
//   OP_BITS  `MC_ALUOp_t_BITS    width of the ALU op field
//
// PORTS
//   clk         in   1        single clock; all state on rising edge
//   reset_n     in   1        asynchronous, active-low reset
//   flush       in   1        synchronous pipeline flush
//   in_valid    in   1        issue request from microcode sequencer
//   in_ready    out  1        stage can accept an issue this cycle
//   in_op       in   OP_BITS  ALU op to forward
//   a_sel       in   2        OpSrc_t for A: REG=0, IMM=1, MEM=2, ZERO=3
//   b_sel       in   2        OpSrc_t for B, same encoding
//   reg_a       in   WIDTH    register-file read port A
//   reg_b       in   WIDTH    register-file read port B
//   imm         in   WIDTH    immediate (already extended)
//   mem_valid   in   1        memory read data valid (one-cycle pulse)
//   mem_data    in   WIDTH    memory read data
//   out_valid   out  1        a/b/op valid to ALU
//   out_ready   in   1        ALU/execute consumes this cycle
//   out_a       out  WIDTH    registered operand A
//   out_b       out  WIDTH    registered operand B
//   out_op      out  OP_BITS  registered op
//   [ALU_OPERAND_BYPASS_EN only]
//   reg_a_idx   in   3        register index behind reg_a
//   reg_b_idx   in   3        register index behind reg_b
//   wb_en       in   1        writeback this cycle
//   wb_idx      in   3        writeback register index
//   wb_data     in   WIDTH    writeback data
//
// BEHAVIOUR
//   - Reset (reset_n low, async):
//     - state=IDLE.
//     - out_valid=0, out_a=0, out_b=0, out_op=0.
//   - States:
//     - IDLE: empty.
//     - WAIT_MEM: captured, waiting for mem_valid.
//     - FULL: out_valid=1.
//   - in_ready = !flush && (IDLE || (FULL && out_ready)). It is 0 in WAIT_MEM.
//   - Accept (in_valid && in_ready):
//     - Capture op, both selects, and the REG/IMM/ZERO operand values.
//     - If no select is MEM, or mem_valid is high the same cycle: go to FULL.
//       MEM operands take mem_data. out_valid rises the next cycle (latency 1).
//     - Otherwise go to WAIT_MEM.
//   - WAIT_MEM:
//     - On mem_valid, latch mem_data into every MEM-selected operand (A, B or both) and go to FULL.
//     - Otherwise hold.
//   - FULL:
//     - out_a/out_b/out_op stay stable while out_valid && !out_ready.
//     - On out_ready with a new accept: reload back to back, no bubble.
//     - On out_ready with no accept: go to IDLE, out_valid=0.
//   - mem_valid is ignored in IDLE, and in FULL unless that cycle has an accept.
//   - flush (highest synchronous priority):
//     - Next state IDLE, out_valid=0. Any pending WAIT_MEM is dropped.
//     - Operand registers keep their values. No accept occurs that cycle.
//   - Reset mid-WAIT_MEM or mid-FULL: immediate return to reset values. No output glitch after release.
//   - No arithmetic: operands pass through unmodified. ZERO yields all zeros.
//
// CONFIGURATION
//   - ALU_OPERAND_BYPASS_EN defined:
//     - Bypass ports exist.
//     - At accept, for a REG-selected operand: if wb_en && wb_idx == its reg_*_idx, wb_data replaces reg_*.
//     - A and B are checked independently.
//   - Undefined: bypass ports absent; reg_a/reg_b are used as-is.
//
// STRUCTURE
//   - Shared package:
//     - OpSrc_t enum (OpSrc_REG/IMM/MEM/ZERO).
//     - OpStage_t state enum.
//     - OP_SRC_BITS=2.
//   - Sub-module operand_select, instanced twice (A, B):
//     - Combinational source mux.
//     - Includes the bypass compare when enabled.
//   - FSM and handshake stay in the top module.
//
// TESTING
//   1. Reset: assert reset_n=0 mid-FULL -> out_valid=0, out_a=out_b=0 asynchronously.
//   2. a_sel=REG, b_sel=IMM, reg_a=16'h1234, imm=16'h00ff, out_ready=1
//      -> next cycle out_valid=1, out_a=16'h1234, out_b=16'h00ff.
//   3. a_sel=MEM, b_sel=MEM, mem_valid 3 cycles late with mem_data=16'hbeef
//      -> in_ready=0 while waiting; then out_a=out_b=16'hbeef.
//   4. Backpressure: out_ready=0 for 4 cycles
//      -> outputs stable, in_ready=0.
//      Then out_ready=1 with in_valid=1 -> second op presented next cycle, no bubble.
//   5. flush in WAIT_MEM, then mem_valid -> state IDLE, out_valid stays 0, mem data ignored.
//   6. BYPASS_EN: reg_a_idx=3, wb_en=1, wb_idx=3, wb_data=16'h5555, reg_a=16'h0000
//      -> out_a=16'h5555.
//      With wb_idx=4 -> out_a=16'h0000.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared types for the ALU operand staging register.
// Rev 1.0
`default_nettype none

`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 4
`endif

package alu_operand_stage_pkg;

    localparam int OP_SRC_BITS = 2;

    typedef enum logic [OP_SRC_BITS-1:0] {
        OpSrc_REG  = 2'd0,
        OpSrc_IMM  = 2'd1,
        OpSrc_MEM  = 2'd2,
        OpSrc_ZERO = 2'd3
    } OpSrc_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_FULL     = 2'd2
    } OpStage_t;

endpackage

`default_nettype wire

// File: rtl/alu_operand_stage_operand_select.sv
// alu_operand_stage_operand_select: combinational operand source mux.
// Rev 1.0 -- optional macro ALU_OPERAND_BYPASS_EN adds writeback bypass on REG sources.
`default_nettype none

module alu_operand_stage_operand_select
    import alu_operand_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  OpSrc_t           sel,
    input  logic [WIDTH-1:0] reg_val,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] mem_data,
`ifdef ALU_OPERAND_BYPASS_EN
    input  logic [2:0]       reg_idx,
    input  logic             wb_en,
    input  logic [2:0]       wb_idx,
    input  logic [WIDTH-1:0] wb_data,
`endif
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] reg_eff;

`ifdef ALU_OPERAND_BYPASS_EN
    // A same-cycle writeback to the register being read is newer than the regfile port.
    assign reg_eff = (wb_en && (wb_idx == reg_idx)) ? wb_data : reg_val;
`else
    assign reg_eff = reg_val;
`endif

    always_comb begin
        value = '0;
        case (sel)
            OpSrc_REG:  value = reg_eff;
            OpSrc_IMM:  value = imm;
            OpSrc_MEM:  value = mem_data;
            OpSrc_ZERO: value = '0;
            default:    value = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered a/b/op staging ahead of the ALU with memory-data stall.
// Rev 1.0 -- optional macro ALU_OPERAND_BYPASS_EN enables writeback bypass ports.
`default_nettype none

module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OP_BITS = `MC_ALUOp_t_BITS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_BITS-1:0] in_op,
    input  logic [1:0]         a_sel,
    input  logic [1:0]         b_sel,
    input  logic [WIDTH-1:0]   reg_a,
    input  logic [WIDTH-1:0]   reg_b,
    input  logic [WIDTH-1:0]   imm,
    input  logic               mem_valid,
    input  logic [WIDTH-1:0]   mem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
`ifdef ALU_OPERAND_BYPASS_EN
    input  logic [2:0]         reg_a_idx,
    input  logic [2:0]         reg_b_idx,
    input  logic               wb_en,
    input  logic [2:0]         wb_idx,
    input  logic [WIDTH-1:0]   wb_data,
`endif
    output logic [OP_BITS-1:0] out_op
);

    OpStage_t         state;
    OpStage_t         state_next;
    OpSrc_t           a_sel_q;
    OpSrc_t           b_sel_q;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic             accept;
    logic             need_mem;

    alu_operand_stage_operand_select #(.WIDTH(WIDTH)) u_sel_a (
        .sel      (OpSrc_t'(a_sel)),
        .reg_val  (reg_a),
        .imm      (imm),
        .mem_data (mem_data),
`ifdef ALU_OPERAND_BYPASS_EN
        .reg_idx  (reg_a_idx),
        .wb_en    (wb_en),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
`endif
        .value    (a_val)
    );

    alu_operand_stage_operand_select #(.WIDTH(WIDTH)) u_sel_b (
        .sel      (OpSrc_t'(b_sel)),
        .reg_val  (reg_b),
        .imm      (imm),
        .mem_data (mem_data),
`ifdef ALU_OPERAND_BYPASS_EN
        .reg_idx  (reg_b_idx),
        .wb_en    (wb_en),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
`endif
        .value    (b_val)
    );

    assign in_ready  = !flush && ((state == ST_IDLE) || ((state == ST_FULL) && out_ready));
    assign accept    = in_valid && in_ready;
    assign need_mem  = (OpSrc_t'(a_sel) == OpSrc_MEM) || (OpSrc_t'(b_sel) == OpSrc_MEM);
    assign out_valid = (state == ST_FULL);

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept)
                        state_next = (need_mem && !mem_valid) ? ST_WAIT_MEM : ST_FULL;
                end
                ST_WAIT_MEM: begin
                    if (mem_valid)
                        state_next = ST_FULL;
                end
                ST_FULL: begin
                    if (accept)
                        state_next = (need_mem && !mem_valid) ? ST_WAIT_MEM : ST_FULL;
                    else if (out_ready)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Operand registers hold across flush; only out_valid is withdrawn.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_a   <= '0;
            out_b   <= '0;
            out_op  <= '0;
            a_sel_q <= OpSrc_REG;
            b_sel_q <= OpSrc_REG;
        end else if (!flush) begin
            if (accept) begin
                out_a   <= a_val;
                out_b   <= b_val;
                out_op  <= in_op;
                a_sel_q <= OpSrc_t'(a_sel);
                b_sel_q <= OpSrc_t'(b_sel);
            end else if ((state == ST_WAIT_MEM) && mem_valid) begin
                if (a_sel_q == OpSrc_MEM)
                    out_a <= mem_data;
                if (b_sel_q == OpSrc_MEM)
                    out_b <= mem_data;
            end
        end
    end

endmodule

`default_nettype wire
